mem_port_responder: RTL and testbench

MEM_PORT_RESPONDER -- requirements
Module: mem_port_responder

---
 rtl/mem_port_responder_if.sv | 22 ++
 rtl/mem_port_responder.sv | 133 +++++++++++++
 tb/tb_mem_port_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_responder_if.sv
// Request/response bus between an initiator (master) and the memory port responder (slave).
interface mem_port_responder_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  valid_1;
    logic                  write_1;
    logic [ADDR_WIDTH-1:0] addr_1;
    logic [WIDTH-1:0]      wdata_1;
    logic                  ready_1;
    logic [WIDTH-1:0]      rdata_1;

    modport master (
        output valid_1, write_1, addr_1, wdata_1,
        input  ready_1, rdata_1
    );

    modport slave (
        input  valid_1, write_1, addr_1, wdata_1,
        output ready_1, rdata_1
    );
endinterface

// File: rtl/mem_port_responder.sv
// Single-port memory target: captures a request, waits WAIT_CYCLES, then pulses ready_1 for one cycle.
module mem_port_responder #(
    parameter int WIDTH       = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk_1,
    input  logic                rstn_1,
    mem_port_responder_if.slave bus,
    output logic [15:0]         wr_count,
    output logic [15:0]         rd_count,
    output logic                proto_err
);
    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  capture;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WIDTH-1:0]      req_wdata;
    logic                  enter_resp;
    logic                  leave_resp;
    logic                  mem_we;
    logic                  ready_q, ready_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic [15:0]           wr_count_q, wr_count_d;
    logic [15:0]           rd_count_q, rd_count_d;
    logic                  proto_err_q, proto_err_d;
    logic [WIDTH-1:0]      mem_q [DEPTH];

    always_ff @(posedge clk_1 or negedge rstn_1) begin
        if (!rstn_1) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.valid_1) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the request is applied on its own capture edge, so use the live inputs then.
    always_comb begin
        req_write   = capture ? bus.write_1 : wr_q;
        req_addr    = capture ? bus.addr_1  : addr_q;
        req_wdata   = capture ? bus.wdata_1 : wdata_q;
        enter_resp  = (state_d == S_RESP) && (state_q != S_RESP);
        leave_resp  = (state_q == S_RESP);
        mem_we      = enter_resp && req_write;
        ready_d     = (state_d == S_RESP);
        rdata_d     = rdata_q;
        if (enter_resp && !req_write) rdata_d = mem_q[req_addr];
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        if (leave_resp && wr_q && (wr_count_q != 16'hFFFF))  wr_count_d = wr_count_q + 16'd1;
        if (leave_resp && !wr_q && (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
        proto_err_d = proto_err_q | ((state_q != S_IDLE) && !bus.valid_1);
    end

    always_ff @(posedge clk_1 or negedge rstn_1) begin
        if (!rstn_1) begin
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (capture) begin
                wr_q    <= bus.write_1;
                addr_q  <= bus.addr_1;
                wdata_q <= bus.wdata_1;
            end
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Memory must clear on reset, so it is a register array rather than block RAM.
    always_ff @(posedge clk_1 or negedge rstn_1) begin
        if (!rstn_1) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[req_addr] <= req_wdata;
        end
    end

    assign bus.ready_1 = ready_q;
    assign bus.rdata_1 = rdata_q;
    assign wr_count    = wr_count_q;
    assign rd_count    = rd_count_q;
    assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench: one responder with one wait state and one with none, driven through the bus interface.
module tb_mem_port_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] wr1, rd1, wr0, rd0;
    logic        pe1, pe0;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    mem_port_responder_if #(.WIDTH(8), .ADDR_WIDTH(4)) b1 ();
    mem_port_responder_if #(.WIDTH(8), .ADDR_WIDTH(4)) b0 ();

    mem_port_responder #(.WIDTH(8), .ADDR_WIDTH(4), .WAIT_CYCLES(1)) u_dut1 (
        .clk_1(clk), .rstn_1(rst_n), .bus(b1.slave),
        .wr_count(wr1), .rd_count(rd1), .proto_err(pe1)
    );

    mem_port_responder #(.WIDTH(8), .ADDR_WIDTH(4), .WAIT_CYCLES(0)) u_dut0 (
        .clk_1(clk), .rstn_1(rst_n), .bus(b0.slave),
        .wr_count(wr0), .rd_count(rd0), .proto_err(pe0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WAIT_CYCLES=1 transfer; valid_1 is left high afterwards unless dropped.
    task automatic txn1(input bit w, input logic [3:0] a, input logic [7:0] d,
                        input bit drop, input bit wiggle, input logic [7:0] exp_rd);
        b1.valid_1 = 1'b1;
        b1.write_1 = w;
        b1.addr_1  = a;
        b1.wdata_1 = d;
        tick();
        check("rdy_capture", {15'd0, b1.ready_1}, 16'd0);
        if (drop) b1.valid_1 = 1'b0;
        if (wiggle) begin
            b1.write_1 = ~w;
            b1.addr_1  = ~a;
            b1.wdata_1 = ~d;
        end
        tick();
        check("rdy_resp", {15'd0, b1.ready_1}, 16'd1);
        if (!w) check("rdata", {8'd0, b1.rdata_1}, {8'd0, exp_rd});
        tick();
        check("rdy_after", {15'd0, b1.ready_1}, 16'd0);
        $display("txn %s addr=%0d data=%h drop=%0b wiggle=%0b", w ? "WR" : "RD", a,
                 w ? d : b1.rdata_1, drop, wiggle);
    endtask

    task automatic idle1(input int n);
        b1.valid_1 = 1'b0;
        repeat (n) tick();
    endtask

    task automatic counts1(input string tag, input logic [15:0] ew, input logic [15:0] er);
        check({tag, "_wr"}, wr1, ew);
        check({tag, "_rd"}, rd1, er);
    endtask

    initial begin
        rst_n = 1'b0;
        b1.valid_1 = 1'b0; b1.write_1 = 1'b0; b1.addr_1 = '0; b1.wdata_1 = '0;
        b0.valid_1 = 1'b0; b0.write_1 = 1'b0; b0.addr_1 = '0; b0.wdata_1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {15'd0, b1.ready_1}, 16'd0);
        check("rst_rdata", {8'd0, b1.rdata_1}, 16'd0);
        counts1("rst", 16'd0, 16'd0);
        check("rst_perr", {15'd0, pe1}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Read of reset memory, then back-to-back write/read.
        txn1(1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 8'h00);
        counts1("rd3", 16'd0, 16'd1);
        txn1(1'b1, 4'd7, 8'hA5, 1'b0, 1'b0, 8'h00);
        txn1(1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 8'hA5);
        counts1("wr7rd7", 16'd1, 16'd2);
        check("perr_b2b", {15'd0, pe1}, 16'd0);

        txn1(1'b1, 4'd0,  8'h5A, 1'b0, 1'b0, 8'h00);
        txn1(1'b1, 4'd15, 8'hC3, 1'b0, 1'b0, 8'h00);
        txn1(1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h5A);
        txn1(1'b0, 4'd15, 8'h00, 1'b0, 1'b0, 8'hC3);
        txn1(1'b0, 4'd7,  8'h00, 1'b0, 1'b0, 8'hA5);
        counts1("multi", 16'd3, 16'd5);

        idle1(3);
        check("idle_rdata", {8'd0, b1.rdata_1}, 16'h00A5);
        check("idle_ready", {15'd0, b1.ready_1}, 16'd0);

        // Inputs changing after capture must be ignored.
        txn1(1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 8'h5A);
        txn1(1'b0, 4'd15, 8'h00, 1'b0, 1'b0, 8'hC3);
        counts1("wiggle", 16'd3, 16'd7);

        // valid_1 dropped during WAIT: sticky error, write still lands.
        txn1(1'b1, 4'd2, 8'hFF, 1'b1, 1'b0, 8'h00);
        check("drop_perr", {15'd0, pe1}, 16'd1);
        check("drop_wr", wr1, 16'd4);
        idle1(1);
        txn1(1'b0, 4'd2, 8'h00, 1'b0, 1'b0, 8'hFF);
        check("perr_sticky", {15'd0, pe1}, 16'd1);
        check("drop_rd", rd1, 16'd8);

        // Reset while ready_1 is high.
        idle1(1);
        b1.valid_1 = 1'b1; b1.write_1 = 1'b1; b1.addr_1 = 4'd5; b1.wdata_1 = 8'h22;
        tick();
        tick();
        check("resp_ready", {15'd0, b1.ready_1}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_resp_ready", {15'd0, b1.ready_1}, 16'd0);
        check("rst_resp_perr", {15'd0, pe1}, 16'd0);
        counts1("rst_resp", 16'd0, 16'd0);
        b1.valid_1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        txn1(1'b0, 4'd5, 8'h00, 1'b0, 1'b0, 8'h00);
        counts1("after_rst_resp", 16'd0, 16'd1);

        // Reset during WAIT of a write discards it.
        idle1(1);
        b1.valid_1 = 1'b1; b1.write_1 = 1'b1; b1.addr_1 = 4'd4; b1.wdata_1 = 8'h11;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_wait_ready", {15'd0, b1.ready_1}, 16'd0);
        b1.valid_1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        txn1(1'b0, 4'd4, 8'h00, 1'b0, 1'b0, 8'h00);
        txn1(1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 8'h00);
        counts1("rst_wait", 16'd0, 16'd2);

        // Saturation of the write counter.
        idle1(1);
        @(negedge clk);
        force u_dut1.wr_count_q = 16'hFFFE;
        #1 release u_dut1.wr_count_q;
        tick();
        txn1(1'b1, 4'd1, 8'h01, 1'b0, 1'b0, 8'h00);
        check("sat1", wr1, 16'hFFFF);
        txn1(1'b1, 4'd1, 8'h02, 1'b0, 1'b0, 8'h00);
        check("sat2", wr1, 16'hFFFF);
        txn1(1'b1, 4'd1, 8'h03, 1'b0, 1'b0, 8'h00);
        check("sat3", wr1, 16'hFFFF);
        check("sat_rd", rd1, 16'd2);
        idle1(1);

        // Zero wait states.
        b0.valid_1 = 1'b1; b0.write_1 = 1'b1; b0.addr_1 = 4'd15; b0.wdata_1 = 8'h3C;
        tick();
        check("w0_wr_ready", {15'd0, b0.ready_1}, 16'd1);
        tick();
        check("w0_wr_done", {15'd0, b0.ready_1}, 16'd0);
        check("w0_wr_cnt", wr0, 16'd1);
        $display("txn WR addr=15 data=3c wait=0");
        b0.write_1 = 1'b0; b0.wdata_1 = 8'h00;
        tick();
        check("w0_rd_ready", {15'd0, b0.ready_1}, 16'd1);
        check("w0_rd_data", {8'd0, b0.rdata_1}, 16'h003C);
        tick();
        check("w0_rd_done", {15'd0, b0.ready_1}, 16'd0);
        check("w0_rd_cnt", rd0, 16'd1);
        check("w0_perr", {15'd0, pe0}, 16'd0);
        $display("txn RD addr=15 data=%h wait=0", b0.rdata_1);
        b0.valid_1 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
